// File: rtl/vga_tile_ctrl.sv
// 640x480@60 tile-mapped video controller: a 20x15 grid of 32x32 tiles, each holding a
// 4-bit colorId, with a CPU write port and a bulk clear that yield to display reads.
module vga_tile_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [8:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    input  logic       clr_req,
    output logic       busy,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [3:0] color_id
);

    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] H_MAX     = 10'd799;
    localparam logic [9:0] HS_BEG    = 10'd656;
    localparam logic [9:0] HS_END    = 10'd751;
    localparam logic [9:0] V_VIS     = 10'd480;
    localparam logic [9:0] V_MAX     = 10'd524;
    localparam logic [9:0] VS_BEG    = 10'd490;
    localparam logic [9:0] VS_END    = 10'd491;
    localparam logic [8:0] LAST_TILE = 9'd299;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      state_r;
    logic [8:0]  clr_ptr_r;
    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [3:0]  tile_r;
    logic [3:0]  mem_r [0:299];
    logic        hsync_r;
    logic        vsync_r;
    logic        video_on_r;
    logic [3:0]  color_id_r;
    logic        wr_ack_r;
    logic        wr_err_r;

    logic        vis_s;
    logic        rd_s;
    logic [8:0]  rd_addr_s;
    logic [3:0]  tile_val_s;
    logic        wr_ok_s;
    logic        wr_go_s;
    logic        clr_go_s;

    // Display read decode and memory-port arbitration; display reads always own the port
    always_comb begin
        vis_s      = 1'b0;
        rd_s       = 1'b0;
        rd_addr_s  = 9'd0;
        tile_val_s = tile_r;
        wr_ok_s    = (wr_addr <= LAST_TILE);
        wr_go_s    = 1'b0;
        clr_go_s   = 1'b0;
        if ((h_cnt_r < H_VIS) && (v_cnt_r < V_VIS)) begin
            vis_s     = 1'b1;
            rd_s      = (h_cnt_r[4:0] == 5'd0);
            rd_addr_s = 9'(v_cnt_r[8:5]) * 9'd20 + 9'(h_cnt_r[9:5]);
        end else begin
            vis_s     = 1'b0;
            rd_s      = 1'b0;
        end
        // The first pixel of a tile uses the fresh read; the tile register covers the rest
        if (rd_s) begin
            tile_val_s = mem_r[rd_addr_s];
        end else begin
            tile_val_s = tile_r;
        end
        if (state_r == ST_CLEAR) begin
            clr_go_s = !rd_s;
            wr_go_s  = 1'b0;
        end else begin
            clr_go_s = 1'b0;
            wr_go_s  = wr_req && !clr_req && !rd_s && !wr_ack_r;
        end
    end

    // Tile memory write port: clear pointer or accepted in-range CPU write
    always_ff @(posedge clk) begin
        if (clr_go_s) begin
            mem_r[clr_ptr_r] <= 4'd0;
        end else if (wr_go_s && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Raster counters and the video outputs registered one cycle behind them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r    <= 10'd0;
            v_cnt_r    <= 10'd0;
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
            video_on_r <= 1'b0;
            color_id_r <= 4'd0;
            tile_r     <= 4'd0;
        end else begin
            if (h_cnt_r == H_MAX) begin
                h_cnt_r <= 10'd0;
                if (v_cnt_r == V_MAX) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
            hsync_r    <= !((h_cnt_r >= HS_BEG) && (h_cnt_r <= HS_END));
            vsync_r    <= !((v_cnt_r >= VS_BEG) && (v_cnt_r <= VS_END));
            video_on_r <= vis_s;
            color_id_r <= vis_s ? tile_val_s : 4'd0;
            if (rd_s) begin
                tile_r <= tile_val_s;
            end
        end
    end

    // Clear sequencer and registered write handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= 9'd0;
            wr_ack_r  <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            wr_ack_r <= wr_go_s;
            wr_err_r <= wr_go_s && !wr_ok_s;
            case (state_r)
                ST_IDLE: begin
                    clr_ptr_r <= 9'd0;
                    if (clr_req) begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_go_s) begin
                        if (clr_ptr_r == LAST_TILE) begin
                            state_r   <= ST_IDLE;
                            clr_ptr_r <= 9'd0;
                        end else begin
                            clr_ptr_r <= clr_ptr_r + 9'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= 9'd0;
                end
            endcase
        end
    end

    assign wr_ack   = wr_ack_r;
    assign wr_err   = wr_err_r;
    assign busy     = (state_r == ST_CLEAR);
    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign video_on = video_on_r;
    assign color_id = color_id_r;

endmodule

// File: doc/vga_tile_ctrl.md
VGA_TILE_CTRL -- requirements
Module: vga_tile_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and one asynchronous, active-high reset, rst.
REQ-002 Port clk  input  1  25 MHz pixel clock; all state SHALL change on its rising edge.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port wr_req  input  1  CPU write request, held high until wr_ack.
REQ-005 Port wr_addr  input  9  tile index, row*20+col, valid 0..299.
REQ-006 Port wr_data  input  4  colorId to store.
REQ-007 Port wr_ack  output  1  one-cycle pulse: the request is consumed.
REQ-008 Port wr_err  output  1  one-cycle pulse with wr_ack when wr_addr > 299.
REQ-009 Port clr_req  input  1  pulse: clear every tile to colorId 0.
REQ-010 Port busy  output  1  high while a clear is in progress.
REQ-011 Port hsync, vsync  output  1 each  active-low sync.
REQ-012 Port video_on  output  1  high for visible pixels.
REQ-013 Port color_id  output  4  colorId for the downstream colour converter.

Function
REQ-014 Timing SHALL be 640x480@60.
- Horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch; h_cnt 0..799.
- Vertical: 480 visible, 10 front porch, 2 sync, 33 back porch; v_cnt 0..524.
REQ-015 h_cnt SHALL wrap from 799 to 0. v_cnt SHALL increment on that wrap and wrap from 524 to 0.
REQ-016 Tile memory SHALL be 300 x 4-bit, single access per cycle, covering a 20x15 grid of 32x32-pixel tiles.
REQ-017 A display read SHALL occur in every cycle where h_cnt<640, v_cnt<480 and h_cnt[4:0]==0.
- Read address: (v_cnt>>5)*20 + (h_cnt>>5).
- The read data SHALL be held in a tile register for the next 31 pixels.
REQ-018 Outputs hsync, vsync, video_on and color_id SHALL be registered and lag the counters by exactly 1 cycle.
- hsync low for h_cnt 656..751.
- vsync low for v_cnt 490..491.
- color_id SHALL be 0 whenever video_on is 0.
REQ-019 Arbitration: the display read SHALL always win.
- A pending CPU write SHALL be serviced in the first free cycle that is not a display-read cycle.
- wr_ack SHALL pulse in that same cycle and the memory SHALL update on that edge.
REQ-020 A write with wr_addr>299 SHALL be acked with wr_err=1 and SHALL leave the memory unchanged.
REQ-021 A new write SHALL NOT be acked in the cycle immediately after a wr_ack; the requester drops wr_req on seeing ack.
REQ-022 The FSM SHALL have the states IDLE and CLEAR.
- IDLE->CLEAR on clr_req.
- In CLEAR, a 9-bit clr_ptr SHALL write 0 to address clr_ptr in each non-display-read cycle, then increment.
- CLEAR->IDLE after address 299 is written.
- busy SHALL equal (state==CLEAR).
REQ-023 During CLEAR, CPU writes SHALL NOT be acked; they remain pending until IDLE.
- clr_req during CLEAR SHALL be ignored.
- clr_req and wr_req in the same IDLE cycle: the clear SHALL win.
REQ-024 Display reads SHALL continue unchanged during CLEAR and return the current memory contents.

Reset
REQ-025 On rst, the block SHALL set h_cnt=0, v_cnt=0, hsync=1, vsync=1, video_on=0, color_id=0, wr_ack=0, wr_err=0.
REQ-026 On rst, the block SHALL set the tile register to 0.
REQ-027 On rst, the block SHALL set state=CLEAR and clr_ptr=0, so busy=1 from reset until the automatic clear completes.
REQ-028 Reset asserted mid-clear or mid-write SHALL abort the operation. No wr_ack SHALL be issued for the aborted write, and the clear SHALL restart from 0.

Verification
REQ-029 The bench SHALL cover the scenarios below.
- Release rst, run ~340 cycles -> busy falls after exactly 300 free cycles; all tiles read back 0; first frame video_on=1 only for 640x480 pixels.
- Write addr 21, data 5 while idle -> wr_ack pulse, wr_err=0; on the next frame, pixels x 32..63, y 32..63 show color_id=5 one cycle after their counters; neighbours show 0.
- Hold wr_req so the first eligible cycle is h_cnt=64, v_cnt=0 (a display read) -> ack is deferred to h_cnt=65; display color_id is unaffected.
- Write addr 300 -> wr_ack and wr_err pulse together; memory is unchanged.
- Pulse clr_req with wr_req pending -> busy=1, no ack during the clear; ack is issued in the first free cycle after busy falls.
- Count cycles: hsync low for 96 cycles each line; vsync low for 1600 cycles each frame; frame period 420000 cycles.
